alu_seq: RTL and testbench

- Parametrised, clocked successor to the datapath's combinational 8-bit ALU.
- Adds a registered result, flags and carry, a start/busy/done handshake, and ADD/SUB with carry chaining.
- Adds a multi-cycle unsigned shift-add multiply producing a double-width product.
- Sits between the register file read ports and the writeback mux; the control unit stalls the PC while BUSY is high.

---
 rtl/alu_seq.sv | 162 ++++++++++++++++
 tb/tb_alu_seq.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Clocked ALU with registered result/flags, carry chaining and a W-cycle
// unsigned shift-add multiply that returns a double-width product.
module alu_seq #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         START,
  input  logic [2:0]   OP,
  input  logic [W-1:0] INPUTA,
  input  logic [W-1:0] INPUTB,
  input  logic         SC_IN,
  input  logic         USE_C,
  output logic [W-1:0] OUT,
  output logic [W-1:0] OUT_HI,
  output logic         SC_OUT,
  output logic         ZERO,
  output logic         BEVEN,
  output logic         BUSY,
  output logic         DONE
);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_LSH = 3'd1;
  localparam logic [2:0] OP_RSH = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic            bev_pend_q, bev_pend_d;
  logic [W-1:0]    out_q, out_d;
  logic [W-1:0]    out_hi_q, out_hi_d;
  logic            sc_q, sc_d;
  logic            zero_q, zero_d;
  logic            beven_q, beven_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            cin;
  logic [W-1:0]    b_op;
  logic [W:0]      sum;
  logic [2*W-1:0]  acc_next;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    bev_pend_d = bev_pend_q;
    out_d      = out_q;
    out_hi_d   = out_hi_q;
    sc_d       = sc_q;
    zero_d     = zero_q;
    beven_d    = beven_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    cin      = USE_C ? sc_q : SC_IN;
    // SUB reuses the adder with inverted B; carry out of 1 means no borrow
    b_op     = (OP == OP_SUB) ? ~INPUTB : INPUTB;
    sum      = {1'b0, INPUTA} + {1'b0, b_op} + (W+1)'(cin);
    acc_next = acc_q + (mplier_q[0] ? mcand_q : {(2*W){1'b0}});

    case (state_q)
      IDLE: begin
        if (START) begin
          if (OP == OP_MUL) begin
            state_d    = MUL_RUN;
            cnt_d      = '0;
            mcand_d    = {{W{1'b0}}, INPUTA};
            mplier_d   = INPUTB;
            acc_d      = '0;
            bev_pend_d = ~INPUTB[0];
            busy_d     = 1'b1;
          end else begin
            done_d   = 1'b1;
            beven_d  = ~INPUTB[0];
            out_hi_d = '0;
            case (OP)
              OP_AND: begin out_d = INPUTA & INPUTB; sc_d = 1'b0; end
              OP_XOR: begin out_d = INPUTA ^ INPUTB; sc_d = 1'b0; end
              OP_LSH: {sc_d, out_d} = {INPUTA, cin};
              OP_RSH: {out_d, sc_d} = {cin, INPUTA};
              OP_ADD, OP_SUB: {sc_d, out_d} = sum;
              default: out_hi_d = out_hi_q;
            endcase
            zero_d = ({out_hi_d, out_d} == '0);
          end
        end
      end
      MUL_RUN: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(W-1)) begin
          state_d  = IDLE;
          cnt_d    = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          out_d    = acc_next[W-1:0];
          out_hi_d = acc_next[2*W-1:W];
          sc_d     = |acc_next[2*W-1:W];
          zero_d   = (acc_next == '0);
          beven_d  = bev_pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      bev_pend_q <= 1'b0;
      out_q      <= '0;
      out_hi_q   <= '0;
      sc_q       <= 1'b0;
      zero_q     <= 1'b0;
      beven_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      bev_pend_q <= bev_pend_d;
      out_q      <= out_d;
      out_hi_q   <= out_hi_d;
      sc_q       <= sc_d;
      zero_q     <= zero_d;
      beven_q    <= beven_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign OUT    = out_q;
  assign OUT_HI = out_hi_q;
  assign SC_OUT = sc_q;
  assign ZERO   = zero_q;
  assign BEVEN  = beven_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors push expected results,
// a monitor pops and compares on every DONE pulse.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] a, b;
  logic       sc_in, use_c;
  logic [7:0] out, out_hi;
  logic       sc_out, zero, beven, busy, done;

  typedef struct packed {
    logic [7:0] out;
    logic [7:0] hi;
    logic       sc;
    logic       z;
    logic       bev;
  } exp_t;

  exp_t q_exp[$];
  exp_t e_mon;
  int   n_vec  = 0;
  int   n_fail = 0;
  int   busy_cnt;
  int   waited;

  always #5 clk = ~clk;

  alu_seq #(.W(8), .CW(4)) dut (
    .CLK(clk), .Reset(reset), .START(start), .OP(op),
    .INPUTA(a), .INPUTB(b), .SC_IN(sc_in), .USE_C(use_c),
    .OUT(out), .OUT_HI(out_hi), .SC_OUT(sc_out), .ZERO(zero),
    .BEVEN(beven), .BUSY(busy), .DONE(done)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q_exp.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_done: got DONE=1 with OUT=%0h, expected no pulse", out);
      end else begin
        e_mon = q_exp.pop_front();
        $display("result OUT=%02h OUT_HI=%02h SC=%0b Z=%0b BEVEN=%0b", out, out_hi, sc_out, zero, beven);
        chk("out",    {8'h0, out},    {8'h0, e_mon.out});
        chk("out_hi", {8'h0, out_hi}, {8'h0, e_mon.hi});
        chk("sc_out", {15'h0, sc_out}, {15'h0, e_mon.sc});
        chk("zero",   {15'h0, zero},   {15'h0, e_mon.z});
        chk("beven",  {15'h0, beven},  {15'h0, e_mon.bev});
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [7:0] ia, input logic [7:0] ib,
                       input logic s, input logic u);
    op = o; a = ia; b = ib; sc_in = s; use_c = u; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic op1(input logic [2:0] o, input logic [7:0] ia, input logic [7:0] ib,
                     input logic s, input logic u, input exp_t e);
    q_exp.push_back(e);
    issue(o, ia, ib, s, u);
    #2 chk("latency1", 16'(q_exp.size()), 16'd0);
    @(negedge clk);
    #1 chk("done_pulse", {15'h0, done}, 16'h0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {out, out_hi}, 16'h0);
    chk(nm, {11'h0, sc_out, zero, beven, busy, done}, 16'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd7; a = '0; b = '0; sc_in = 1'b0; use_c = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);

    op1(3'd4, 8'h12, 8'h34, 1'b0, 1'b0, '{8'h46, 8'h00, 1'b0, 1'b0, 1'b1});
    op1(3'd4, 8'hFF, 8'h01, 1'b0, 1'b0, '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0});
    op1(3'd4, 8'h00, 8'h00, 1'b0, 1'b1, '{8'h01, 8'h00, 1'b0, 1'b0, 1'b1});
    op1(3'd5, 8'h05, 8'h07, 1'b1, 1'b0, '{8'hFE, 8'h00, 1'b0, 1'b0, 1'b0});
    op1(3'd0, 8'hF0, 8'h3C, 1'b0, 1'b0, '{8'h30, 8'h00, 1'b0, 1'b0, 1'b1});
    op1(3'd3, 8'hAA, 8'hAA, 1'b1, 1'b0, '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1});
    op1(3'd2, 8'h81, 8'h00, 1'b0, 1'b0, '{8'h40, 8'h00, 1'b1, 1'b0, 1'b1});
    op1(3'd1, 8'h81, 8'h00, 1'b1, 1'b0, '{8'h03, 8'h00, 1'b1, 1'b0, 1'b1});
    op1(3'd7, 8'h55, 8'h01, 1'b0, 1'b0, '{8'h03, 8'h00, 1'b1, 1'b0, 1'b0});

    // MUL FF*FF with a stray START while busy
    q_exp.push_back('{8'h01, 8'hFE, 1'b1, 1'b0, 1'b0});
    issue(3'd6, 8'hFF, 8'hFF, 1'b0, 1'b0);
    busy_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (!busy) break;
      busy_cnt++;
      if (c == 2) chk("hold_mid_mul", {8'h0, out}, 16'h0003);
      if (c == 3) begin op = 3'd4; a = 8'h01; b = 8'h01; start = 1'b1; end
      if (c == 4) start = 1'b0;
      @(negedge clk);
    end
    chk("busy_cycles", 16'(busy_cnt), 16'd8);
    #2 chk("mul_done", 16'(q_exp.size()), 16'd0);
    repeat (3) @(negedge clk);

    // MUL aborted by reset four cycles in
    issue(3'd6, 8'h0D, 8'h0B, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_all_zero("abort_state");
    repeat (12) @(negedge clk);
    chk_all_zero("abort_quiet");

    q_exp.push_back('{8'h00, 8'h00, 1'b0, 1'b1, 1'b0});
    issue(3'd6, 8'h00, 8'h09, 1'b0, 1'b0);
    waited = 0;
    while (q_exp.size() != 0 && waited < 30) begin
      @(negedge clk);
      #1 waited++;
    end
    chk("mul_zero_timeout", 16'(q_exp.size()), 16'd0);
    chk("mul_zero_busy", {15'h0, busy}, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
